dvp_video_tx: RTL and testbench

//  OV5640-style DVP transmitter: generates cam_vsync/cam_href/cam_data (8-bit, RGB565, high byte first).

---
 rtl/ov5640_dvp_pkg.sv | 33 +++
 rtl/dvp_timing_gen.sv | 102 ++++++++++
 rtl/dvp_video_tx.sv | 154 +++++++++++++++
 tb/tb_dvp_video_tx.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/ov5640_dvp_pkg.sv
// Shared timing defaults, colour-bar table and FSM state type for the DVP transmitter.
package ov5640_dvp_pkg;

  localparam int DEF_H_DISP   = 1024;
  localparam int DEF_V_DISP   = 768;
  localparam int DEF_H_TOTAL  = 2240;
  localparam int DEF_V_TOTAL  = 1272;
  localparam int DEF_VS_LINES = 4;
  localparam int DEF_VBP      = 16;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } dvp_state_e;

  // RGB565 colour of bar idx, left to right: white, yellow, cyan, green, magenta, red, blue, black.
  function automatic logic [15:0] bar_color(input logic [2:0] idx);
    logic [15:0] c;
    case (idx)
      3'd0:    c = 16'hFFFF;
      3'd1:    c = 16'hFFE0;
      3'd2:    c = 16'h07FF;
      3'd3:    c = 16'h07E0;
      3'd4:    c = 16'hF81F;
      3'd5:    c = 16'hF800;
      3'd6:    c = 16'h001F;
      3'd7:    c = 16'h0000;
      default: c = 16'h0000;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/dvp_timing_gen.sv
// Byte/line counters, IDLE/RUN frame FSM and stage-0 decode of the raster position.
module dvp_timing_gen
  import ov5640_dvp_pkg::*;
#(
  parameter int H_DISP   = DEF_H_DISP,
  parameter int V_DISP   = DEF_V_DISP,
  parameter int H_TOTAL  = DEF_H_TOTAL,
  parameter int V_TOTAL  = DEF_V_TOTAL,
  parameter int VS_LINES = DEF_VS_LINES,
  parameter int VBP      = DEF_VBP
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic tx_en_i,
  input  logic pat_en_i,
  output logic run_o,
  output logic act_o,
  output logic vs_o,
  output logic fs_o,
  output logic hi_o,
  output logic mode_o
);

  localparam int BYTE_W = $clog2(2 * H_TOTAL);
  localparam int LINE_W = $clog2(V_TOTAL);
  localparam logic [BYTE_W-1:0] BYTE_LAST = BYTE_W'(2 * H_TOTAL - 1);
  localparam logic [BYTE_W-1:0] BYTE_ACT  = BYTE_W'(2 * H_DISP);
  localparam logic [LINE_W-1:0] LINE_LAST = LINE_W'(V_TOTAL - 1);
  localparam logic [LINE_W-1:0] LINE_A0   = LINE_W'(VS_LINES + VBP);
  localparam logic [LINE_W-1:0] LINE_A1   = LINE_W'(VS_LINES + VBP + V_DISP - 1);
  localparam logic [LINE_W-1:0] LINE_VS   = LINE_W'(VS_LINES);

  dvp_state_e        state_q, state_d;
  logic [BYTE_W-1:0] byte_cnt_q, byte_cnt_d;
  logic [LINE_W-1:0] line_cnt_q, line_cnt_d;
  logic              mode_q, mode_d;

  // State, counters and latched source mode.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      byte_cnt_q <= '0;
      line_cnt_q <= '0;
      mode_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      byte_cnt_q <= byte_cnt_d;
      line_cnt_q <= line_cnt_d;
      mode_q     <= mode_d;
    end
  end

  // Frame sequencing: enable and mode are only looked at on a frame boundary.
  always_comb begin
    state_d    = state_q;
    byte_cnt_d = byte_cnt_q;
    line_cnt_d = line_cnt_q;
    mode_d     = mode_q;
    case (state_q)
      IDLE: begin
        byte_cnt_d = '0;
        line_cnt_d = '0;
        if (tx_en_i) begin
          state_d = RUN;
          mode_d  = pat_en_i;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        if (byte_cnt_q == BYTE_LAST) begin
          byte_cnt_d = '0;
          if (line_cnt_q == LINE_LAST) begin
            line_cnt_d = '0;
            if (tx_en_i) begin
              mode_d = pat_en_i;
            end else begin
              state_d = IDLE;
            end
          end else begin
            line_cnt_d = line_cnt_q + LINE_W'(1);
          end
        end else begin
          byte_cnt_d = byte_cnt_q + BYTE_W'(1);
        end
      end
      default: begin
        state_d    = IDLE;
        byte_cnt_d = '0;
        line_cnt_d = '0;
      end
    endcase
  end

  assign run_o  = (state_q == RUN);
  assign act_o  = run_o && (line_cnt_q >= LINE_A0) && (line_cnt_q <= LINE_A1) && (byte_cnt_q < BYTE_ACT);
  assign vs_o   = run_o && (line_cnt_q < LINE_VS);
  assign fs_o   = run_o && (line_cnt_q == '0) && (byte_cnt_q == '0);
  assign hi_o   = ~byte_cnt_q[0];
  assign mode_o = mode_q;

endmodule

// File: rtl/dvp_video_tx.sv
// OV5640-style DVP transmitter: pixel request, colour bars and the 2-stage output pipeline.
module dvp_video_tx
  import ov5640_dvp_pkg::*;
#(
  parameter int H_DISP   = DEF_H_DISP,
  parameter int V_DISP   = DEF_V_DISP,
  parameter int H_TOTAL  = DEF_H_TOTAL,
  parameter int V_TOTAL  = DEF_V_TOTAL,
  parameter int VS_LINES = DEF_VS_LINES,
  parameter int VBP      = DEF_VBP
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic        tx_en,
  input  logic        pat_en,
  output logic        pix_req,
  input  logic [15:0] pix_data,
  output logic        cam_vsync,
  output logic        cam_href,
  output logic [7:0]  cam_data,
  output logic        frame_start,
  output logic        busy
);

  localparam int BAR_PIX = H_DISP / 8;
  localparam int BAR_W   = (BAR_PIX > 1) ? $clog2(BAR_PIX) : 1;
  localparam logic [BAR_W-1:0] BAR_LAST = BAR_W'(BAR_PIX - 1);

  logic run_s, act_s, vs_s, fs_s, hi_s, mode_s;

  dvp_timing_gen #(
    .H_DISP  (H_DISP),
    .V_DISP  (V_DISP),
    .H_TOTAL (H_TOTAL),
    .V_TOTAL (V_TOTAL),
    .VS_LINES(VS_LINES),
    .VBP     (VBP)
  ) u_timing (
    .clk_i   (sys_clk),
    .rst_ni  (sys_rst_n),
    .tx_en_i (tx_en),
    .pat_en_i(pat_en),
    .run_o   (run_s),
    .act_o   (act_s),
    .vs_o    (vs_s),
    .fs_o    (fs_s),
    .hi_o    (hi_s),
    .mode_o  (mode_s)
  );

  // One read per pixel, on its high-byte slot, only when streaming from the FIFO.
  assign pix_req = act_s & hi_s & ~mode_s;

  logic [BAR_W-1:0] bar_pix_q, bar_pix_d;
  logic [2:0]       bar_idx_q, bar_idx_d;

  // Pixel-within-bar and bar index counters replace a divide of the pixel column.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      bar_pix_q <= '0;
      bar_idx_q <= 3'd0;
    end else begin
      bar_pix_q <= bar_pix_d;
      bar_idx_q <= bar_idx_d;
    end
  end

  // Advance after each low byte; restart at every line's active region.
  always_comb begin
    bar_pix_d = bar_pix_q;
    bar_idx_d = bar_idx_q;
    if (!act_s) begin
      bar_pix_d = '0;
      bar_idx_d = 3'd0;
    end else if (!hi_s) begin
      if (bar_pix_q == BAR_LAST) begin
        bar_pix_d = '0;
        bar_idx_d = bar_idx_q + 3'd1;
      end else begin
        bar_pix_d = bar_pix_q + BAR_W'(1);
      end
    end else begin
      bar_pix_d = bar_pix_q;
    end
  end

  logic        act1_q, vs1_q, fs1_q, hi1_q, run1_q, src_bar1_q;
  logic [15:0] bar1_q;

  // Stage 1: control delayed one cycle while the FIFO word arrives; bar colour registered.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      act1_q     <= 1'b0;
      vs1_q      <= 1'b0;
      fs1_q      <= 1'b0;
      hi1_q      <= 1'b0;
      run1_q     <= 1'b0;
      src_bar1_q <= 1'b0;
      bar1_q     <= 16'h0000;
    end else begin
      act1_q     <= act_s;
      vs1_q      <= vs_s;
      fs1_q      <= fs_s;
      hi1_q      <= hi_s;
      run1_q     <= run_s;
      src_bar1_q <= mode_s;
      bar1_q     <= bar_color(bar_idx_q);
    end
  end

  logic [15:0] pixel_s;
  logic [7:0]  held_q, held_d, data_d;
  logic        run2_q;

  // Pick the pixel source; split into high byte now and low byte next cycle.
  always_comb begin
    pixel_s = src_bar1_q ? bar1_q : pix_data;
    held_d  = held_q;
    data_d  = 8'h00;
    if (act1_q) begin
      if (hi1_q) begin
        data_d = pixel_s[15:8];
        held_d = pixel_s[7:0];
      end else begin
        data_d = held_q;
      end
    end else begin
      data_d = 8'h00;
    end
  end

  // Stage 2: registered DVP outputs, all aligned to the same pixel position.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      cam_data    <= 8'h00;
      held_q      <= 8'h00;
      cam_href    <= 1'b0;
      cam_vsync   <= 1'b0;
      frame_start <= 1'b0;
      run2_q      <= 1'b0;
    end else begin
      cam_data    <= data_d;
      held_q      <= held_d;
      cam_href    <= act1_q;
      cam_vsync   <= vs1_q;
      frame_start <= fs1_q;
      run2_q      <= run1_q;
    end
  end

  // Busy covers the frame plus the two pipeline stages still draining.
  assign busy = run_s | run1_q | run2_q;

endmodule

// File: tb/tb_dvp_video_tx.sv
// Randomized self-checking bench for dvp_video_tx against a frame-position reference model.
module tb_dvp_video_tx;

  localparam int HD    = 8;
  localparam int HT    = 10;
  localparam int VD    = 2;
  localparam int VT    = 6;
  localparam int VSL   = 1;
  localparam int VBPL  = 1;
  localparam int LB    = 2 * HT;
  localparam int FRAME = LB * VT;
  localparam logic [15:0] BARS [0:7] = '{16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0,
                                         16'hF81F, 16'hF800, 16'h001F, 16'h0000};

  logic        sys_clk = 1'b0;
  logic        sys_rst_n;
  logic        tx_en;
  logic        pat_en;
  logic        pix_req;
  logic [15:0] pix_data;
  logic        cam_vsync;
  logic        cam_href;
  logic [7:0]  cam_data;
  logic        frame_start;
  logic        busy;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: frame position (-1 = idle) for the current and three earlier cycles.
  int          p0 = -1, p1 = -1, p2 = -1, p3 = -1;
  bit          m0 = 1'b0, m1 = 1'b0, m2 = 1'b0, m3 = 1'b0;
  logic [15:0] pd1 = 16'h0000, pd2 = 16'h0000;

  dvp_video_tx #(
    .H_DISP(HD), .V_DISP(VD), .H_TOTAL(HT), .V_TOTAL(VT), .VS_LINES(VSL), .VBP(VBPL)
  ) dut (
    .sys_clk    (sys_clk),
    .sys_rst_n  (sys_rst_n),
    .tx_en      (tx_en),
    .pat_en     (pat_en),
    .pix_req    (pix_req),
    .pix_data   (pix_data),
    .cam_vsync  (cam_vsync),
    .cam_href   (cam_href),
    .cam_data   (cam_data),
    .frame_start(frame_start),
    .busy       (busy)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic check_val(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic bit in_act(input int p);
    int line, b;
    if (p < 0) return 1'b0;
    line = p / LB;
    b    = p % LB;
    return (line >= VSL + VBPL) && (line < VSL + VBPL + VD) && (b < 2 * HD);
  endfunction

  function automatic logic [15:0] bar_of(input int p);
    int col;
    col = ((p % LB) / 2) / (HD / 8);
    return BARS[col];
  endfunction

  task automatic check_outputs();
    logic        e_req, e_href, e_vs, e_fs, e_busy;
    logic [15:0] px;
    logic [7:0]  e_data;
    e_req  = in_act(p0) && ((p0 % 2) == 0) && !m0;
    e_href = in_act(p2);
    e_vs   = (p2 >= 0) && ((p2 / LB) < VSL);
    e_fs   = (p2 == 0);
    e_busy = (p0 >= 0) || (p1 >= 0) || (p2 >= 0);
    e_data = 8'h00;
    if (in_act(p2)) begin
      if ((p2 % 2) == 0) begin
        px     = m2 ? bar_of(p2) : pd1;
        e_data = px[15:8];
      end else begin
        px     = m3 ? bar_of(p3) : pd2;
        e_data = px[7:0];
      end
    end
    check_val("pix_req",     {15'd0, pix_req},     {15'd0, e_req});
    check_val("cam_href",    {15'd0, cam_href},    {15'd0, e_href});
    check_val("cam_vsync",   {15'd0, cam_vsync},   {15'd0, e_vs});
    check_val("frame_start", {15'd0, frame_start}, {15'd0, e_fs});
    check_val("busy",        {15'd0, busy},        {15'd0, e_busy});
    check_val("cam_data",    {8'd0, cam_data},     {8'd0, e_data});
  endtask

  // One clock: advance the model at the rising edge, check at the falling edge, new FIFO word.
  task automatic step();
    @(posedge sys_clk);
    p3 = p2; m3 = m2;
    p2 = p1; m2 = m1;
    p1 = p0; m1 = m0;
    pd2 = pd1;
    pd1 = pix_data;
    if (!sys_rst_n) begin
      p0 = -1; p1 = -1; p2 = -1; p3 = -1;
    end else if (p1 < 0 || p1 == FRAME - 1) begin
      if (tx_en) begin
        p0 = 0;
        m0 = pat_en;
      end else begin
        p0 = -1;
      end
    end else begin
      p0 = p1 + 1;
      m0 = m1;
    end
    @(negedge sys_clk);
    check_outputs();
    pix_data = 16'($urandom);
  endtask

  task automatic run_cycles(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    sys_rst_n = 1'b1;
    tx_en     = 1'b0;
    pat_en    = 1'b0;
    pix_data  = 16'h1234;
    #1 sys_rst_n = 1'b0;
    run_cycles(4);
    sys_rst_n = 1'b1;
    run_cycles(5);

    // FIFO-sourced frames, back to back; pat_en flipped mid-frame must wait for the boundary.
    tx_en = 1'b1;
    run_cycles(FRAME / 2);
    pat_en = 1'b1;
    run_cycles(FRAME);
    // Pattern frames; switch back mid-frame.
    run_cycles(FRAME / 3);
    pat_en = 1'b0;
    run_cycles(FRAME);

    // Drop enable mid-frame: frame completes, then idle; re-raise later.
    run_cycles(FRAME / 4);
    tx_en = 1'b0;
    run_cycles(FRAME + 10);
    pat_en = 1'b1;
    tx_en  = 1'b1;
    run_cycles(2 * FRAME + 3);

    // Random enable/mode activity.
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 199) == 0) tx_en = ~tx_en;
      if ($urandom_range(0, 49) == 0) pat_en = ~pat_en;
      step();
    end

    // Asynchronous reset in the middle of an href burst.
    tx_en  = 1'b1;
    pat_en = 1'b0;
    begin : rst_mid
      int k;
      k = 0;
      while (!in_act(p2) && k < 3 * FRAME) begin
        step();
        k++;
      end
      check_val("href_before_rst", {15'd0, cam_href}, 16'd1);
      sys_rst_n = 1'b0;
      p0 = -1; p1 = -1; p2 = -1; p3 = -1;
      #1;
      check_val("rst_pix_req",     {15'd0, pix_req},     16'd0);
      check_val("rst_cam_href",    {15'd0, cam_href},    16'd0);
      check_val("rst_cam_vsync",   {15'd0, cam_vsync},   16'd0);
      check_val("rst_frame_start", {15'd0, frame_start}, 16'd0);
      check_val("rst_busy",        {15'd0, busy},        16'd0);
      check_val("rst_cam_data",    {8'd0, cam_data},     16'd0);
    end
    run_cycles(3);
    sys_rst_n = 1'b1;
    run_cycles(FRAME + 8);
    tx_en = 1'b0;
    run_cycles(FRAME + 5);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
